// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches and buffers
// returned instructions with their PCs for a valid/ready handshake to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]            pc_q, pc_d;
  logic [DEPTH-1:0][31:0] ent_pc_q, ent_pc_d;
  logic [DEPTH-1:0][31:0] ent_instr_q, ent_instr_d;
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [PtrW-1:0]        fill_q, fill_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [CntW-1:0]        unfilled_q, unfilled_d;
  logic [CntW-1:0]        drop_q, drop_d;

  logic            accept;
  logic            pop;
  logic            fill_en;
  logic [CntW:0]   credits_used;

  // Credits cover both live entries and responses still owed for flushed ones.
  assign credits_used = {1'b0, count_q} + {1'b0, drop_q};

  always_comb begin
    imem_req_valid = rst_n & ~redirect_valid & (credits_used < (CntW + 1)'(DEPTH));
    imem_req_addr  = pc_q;
    dec_valid      = filled_q[head_q] & ~redirect_valid;
    dec_instr      = Nop;
    dec_pc         = '0;
    if (dec_valid) begin
      dec_instr = ent_instr_q[head_q];
      dec_pc    = ent_pc_q[head_q];
    end
  end

  assign accept  = imem_req_valid & imem_req_ready;
  assign pop     = dec_valid & dec_ready;
  assign fill_en = imem_rsp_valid & ~redirect_valid & (drop_q == '0) & (unfilled_q != '0);

  always_comb begin
    pc_d        = pc_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    filled_d    = filled_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    count_d     = count_q;
    unfilled_d  = unfilled_q;
    drop_d      = drop_q;
    if (redirect_valid) begin
      // Everything allocated but unfilled becomes a stale response to swallow;
      // a response landing this cycle is itself one of those.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      filled_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      drop_d     = drop_q + unfilled_q - CntW'(imem_rsp_valid);
    end else begin
      if (imem_rsp_valid && drop_q != '0) begin
        drop_d = drop_q - CntW'(1);
      end
      if (fill_en) begin
        ent_instr_d[fill_q] = imem_rsp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + PtrW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PtrW'(1);
      end
      if (accept) begin
        ent_pc_d[tail_q] = pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PtrW'(1);
        pc_d             = pc_q + 32'd4;
      end
      count_d    = count_q + CntW'(accept) - CntW'(pop);
      unfilled_d = unfilled_q + CntW'(accept) - CntW'(fill_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ent_pc_q    <= '0;
      ent_instr_q <= '0;
      filled_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
      drop_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
      filled_q    <= filled_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      unfilled_q  <= unfilled_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory, queue-level reference model
// compared every cycle, plus literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam int          Depth = 4;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b1;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RstPc), .DEPTH(Depth)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: responses in request order, each due `lat` cycles after accept.
  int          mem_due[$];
  logic [31:0] mem_data[$];
  int          lat = 1;
  int          cyc = 0;

  // Reference model: queue of fetched PCs with a filled flag, plus owed stale responses.
  logic [31:0] q_pc[$];
  bit          q_filled[$];
  logic [31:0] m_pc;
  int          m_drop;

  logic        s_req_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;

  task automatic model_reset();
    q_pc.delete();
    q_filled.delete();
    mem_due.delete();
    mem_data.delete();
    m_pc   = RstPc;
    m_drop = 0;
  endtask

  // Called at a negedge with dec_ready/redirect/req_ready already set; ends at next negedge.
  task automatic cycle();
    bit          m_req, m_dec, pop, done;
    int          unf;
    logic [31:0] e_pc, e_instr;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data[0];
      void'(mem_due.pop_front());
      void'(mem_data.pop_front());
    end
    #1;
    m_req   = !redirect_valid && (q_pc.size() + m_drop < Depth);
    m_dec   = !redirect_valid && q_pc.size() > 0 && q_filled[0];
    e_pc    = m_dec ? q_pc[0] : 32'h0;
    e_instr = m_dec ? mem_word(q_pc[0]) : Nop;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_dec_valid = dec_valid;
    s_dec_pc    = dec_pc;
    s_dec_instr = dec_instr;
    chk("req_valid", {31'b0, s_req_valid}, {31'b0, m_req});
    chk("req_addr", s_req_addr, m_pc);
    chk("dec_valid", {31'b0, s_dec_valid}, {31'b0, m_dec});
    chk("dec_pc", s_dec_pc, e_pc);
    chk("dec_instr", s_dec_instr, e_instr);
    if (imem_req_valid && imem_req_ready) begin
      mem_due.push_back(cyc + lat);
      mem_data.push_back(mem_word(imem_req_addr));
    end
    if (redirect_valid) begin
      unf = 0;
      foreach (q_filled[i]) if (!q_filled[i]) unf++;
      m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
      q_pc.delete();
      q_filled.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop = m_dec && dec_ready;
      if (imem_rsp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          done = 1'b0;
          foreach (q_filled[i]) begin
            if (!done && !q_filled[i]) begin
              q_filled[i] = 1'b1;
              done = 1'b1;
            end
          end
        end
      end
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_filled.pop_front());
      end
      if (m_req && imem_req_ready) begin
        q_pc.push_back(m_pc);
        q_filled.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_dec(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_dec_valid) found = 1'b1;
    end
    chk(name, {31'b0, found}, 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_dec_instr", dec_instr, Nop);
    chk("rst_dec_pc", dec_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming, k=1, always ready.
    cycle();
    chk("a0_req_valid", {31'b0, s_req_valid}, 32'd1);
    chk("a0_req_addr", s_req_addr, 32'h0000_0100);
    cycle();
    chk("a1_req_addr", s_req_addr, 32'h0000_0104);
    chk("a1_dec_valid", {31'b0, s_dec_valid}, 32'd0);
    cycle();
    chk("a2_req_addr", s_req_addr, 32'h0000_0108);
    chk("a2_dec_pc", s_dec_pc, 32'h0000_0100);
    chk("a2_dec_instr", s_dec_instr, 32'hA5A5_0100);
    repeat (5) cycle();

    // Decode stall: credits exhaust, head stays put.
    dec_ready = 1'b0;
    repeat (10) cycle();
    chk("stall_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("stall_dec_pc", s_dec_pc, 32'h0000_0118);
    chk("stall_dec_instr", s_dec_instr, 32'hA5A5_0118);
    dec_ready = 1'b1;
    repeat (6) cycle();

    // Slow memory, redirect with responses outstanding and unaligned target.
    lat = 3;
    repeat (5) cycle();
    redirect_to(32'h0000_2003);
    cycle();
    chk("redir_req_addr", s_req_addr, 32'h0000_2000);
    wait_dec("redir_wait");
    chk("redir_dec_pc", s_dec_pc, 32'h0000_2000);
    chk("redir_dec_instr", s_dec_instr, 32'hA5A5_2000);

    // Redirect coinciding with a response while one more is outstanding.
    imem_req_ready = 1'b0;
    redirect_to(32'h0000_3000);
    repeat (8) cycle();
    lat = 2;
    imem_req_ready = 1'b1;
    cycle();
    cycle();
    imem_req_ready = 1'b0;
    redirect_to(32'h0000_4000);
    chk("coinc_rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
    chk("coinc_dec_valid", {31'b0, s_dec_valid}, 32'd0);
    imem_req_ready = 1'b1;
    lat = 1;
    wait_dec("coinc_wait");
    chk("coinc_dec_pc", s_dec_pc, 32'h0000_4000);

    // PC wrap-around.
    redirect_to(32'hFFFF_FFFC);
    cycle();
    chk("wrap_req0", s_req_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_req1", s_req_addr, 32'h0000_0000);
    wait_dec("wrap_wait");
    chk("wrap_dec0", s_dec_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_dec1", s_dec_pc, 32'h0000_0000);

    // Asynchronous reset mid-stream with the queue full.
    dec_ready = 1'b0;
    repeat (8) cycle();
    chk("full_req_valid", {31'b0, s_req_valid}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("arst_dec_instr", dec_instr, Nop);
    chk("arst_dec_pc", dec_pc, 32'd0);
    model_reset();
    imem_rsp_valid = 1'b0;
    dec_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("restart_req_valid", {31'b0, s_req_valid}, 32'd1);
    chk("restart_req_addr", s_req_addr, RstPc);
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
